// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus between the core (master) and the memory/I/O responder (slave).
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a,
    output mem_dout,
    output mem_wr,
    input  mem_din,
    input  io_buffer_full
  );

  modport slave (
    input  mem_a,
    input  mem_dout,
    input  mem_wr,
    output mem_din,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: 128 KB RAM plus UART and cycle-counter registers
// in the 0x3xxxx window, with the TX FIFO that feeds the UART transmitter.
module mem_io_responder #(
  parameter int RAM_AW        = 17,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int FULL_MARGIN   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_pop,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                program_stop,
  output logic                tx_overflow
);

  localparam int              DEPTH    = 1 << TX_DEPTH_LOG2;
  localparam int              CW       = TX_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   MARGIN_C = CW'(FULL_MARGIN);

  typedef enum logic [2:0] {
    REG_NONE,
    REG_UART,
    REG_CNT0,
    REG_CNT1,
    REG_CNT2,
    REG_CNT3
  } io_reg_e;

  logic                     io_sel;
  logic [RAM_AW-1:0]        ram_idx;
  io_reg_e                  io_reg;
  logic                     rd_en;
  logic                     wr_en;
  logic                     unused_addr;

  logic [7:0]               ram [2**RAM_AW];
  logic [7:0]               io_rdata;
  logic [31:0]              cycle_cnt;
  logic [31:0]              snapshot;

  logic [7:0]               fifo_mem [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]            count;
  logic                     push_req;
  logic                     push_ok;
  logic                     pop;
  logic [7:0]               push_byte;

  assign io_sel      = (bus.mem_a[17:16] == 2'b11);
  assign ram_idx     = bus.mem_a[RAM_AW-1:0];
  assign unused_addr = ^bus.mem_a[31:18];
  assign rd_en       = !rst_in && !bus.mem_wr;
  assign wr_en       = !rst_in && bus.mem_wr;

  always_comb begin
    io_reg = REG_NONE;
    if (io_sel) begin
      case (bus.mem_a[15:0])
        16'h0000: io_reg = REG_UART;
        16'h0004: io_reg = REG_CNT0;
        16'h0005: io_reg = REG_CNT1;
        16'h0006: io_reg = REG_CNT2;
        16'h0007: io_reg = REG_CNT3;
        default:  io_reg = REG_NONE;
      endcase
    end
  end

  assign rx_pop       = rd_en && (io_reg == REG_UART) && rx_valid;
  assign program_stop = wr_en && (io_reg == REG_CNT0);

  // A stop write queues a literal 0x00 so the host sees a terminator; UART zeros are filtered.
  assign push_req  = wr_en && (((io_reg == REG_UART) && (bus.mem_dout != 8'h00)) ||
                               (io_reg == REG_CNT0));
  assign push_byte = (io_reg == REG_CNT0) ? 8'h00 : bus.mem_dout;

  always_ff @(posedge clk_in) begin
    if (wr_en && !io_sel) begin
      ram[ram_idx] <= bus.mem_dout;
    end
  end

  // Upper counter bytes come from the snapshot so a 4-byte load is coherent.
  always_comb begin
    io_rdata = 8'h00;
    case (io_reg)
      REG_UART: io_rdata = rx_valid ? rx_data : 8'h00;
      REG_CNT0: io_rdata = cycle_cnt[7:0];
      REG_CNT1: io_rdata = snapshot[15:8];
      REG_CNT2: io_rdata = snapshot[23:16];
      REG_CNT3: io_rdata = snapshot[31:24];
      default:  io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.mem_din <= 8'h00;
    end else if (!bus.mem_wr) begin
      bus.mem_din <= io_sel ? io_rdata : ram[ram_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= 32'h0;
      snapshot  <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'h1;
      if (rd_en && (io_reg == REG_CNT0)) begin
        snapshot <= cycle_cnt;
      end
    end
  end

  assign pop     = tx_valid && tx_ready;
  assign push_ok = push_req && ((count != DEPTH_C) || pop);

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  assign tx_valid = (count != '0);
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  // Asserting early leaves room for stores the CPU already has in flight.
  assign bus.io_buffer_full = ((DEPTH_C - count) <= MARGIN_C);

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM latency, TX FIFO filtering/overflow,
// coherent counter reads, UART RX pops, program stop and mid-run reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] assembled;

  always #5 clk_in = ~clk_in;

  mem_io_responder_if bus ();

  mem_io_responder #(
    .RAM_AW       (17),
    .TX_DEPTH_LOG2(4),
    .FULL_MARGIN  (2)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus         (bus),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_pop      (rx_pop),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .program_stop(program_stop),
    .tx_overflow (tx_overflow)
  );

  task automatic apply_stimulus(input logic [31:0] addr, input logic wr, input logic [7:0] dout);
    bus.mem_a    = addr;
    bus.mem_wr   = wr;
    bus.mem_dout = dout;
    #1;
  endtask

  task automatic apply_idle();
    apply_stimulus(32'h0003_0008, 1'b1, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in    = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b1;
    tx_ready  = 1'b0;
    assembled = 32'h0;

    // Reset state; a UART read during reset must not pop
    apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
    check_output("rst_rx_pop", 32'(rx_pop), 32'h0);
    tick();
    tick();
    check_output("rst_mem_din", 32'(bus.mem_din), 32'h0);
    check_output("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_output("rst_tx_data", 32'(tx_data), 32'h0);
    check_output("rst_buf_full", 32'(bus.io_buffer_full), 32'h0);
    check_output("rst_overflow", 32'(tx_overflow), 32'h0);
    check_output("rst_prog_stop", 32'(program_stop), 32'h0);
    check_output("rst_counter", dut.cycle_cnt, 32'h0);
    rx_valid = 1'b0;
    apply_idle();
    rst_in = 1'b0;
    tick();

    // RAM write then read with one-cycle latency
    apply_stimulus(32'h0000_0010, 1'b1, 8'hA5);
    tick();
    apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
    check_output("ram_lat_before_edge", 32'(bus.mem_din), 32'h0);
    tick();
    check_output("ram_rd_0x10", 32'(bus.mem_din), 32'hA5);

    apply_stimulus(32'h0001_FFFF, 1'b1, 8'h3C);
    tick();
    apply_stimulus(32'h0000_0000, 1'b1, 8'hC3);
    tick();
    apply_stimulus(32'h0001_FFFF, 1'b0, 8'h00);
    tick();
    check_output("ram_rd_0x1ffff", 32'(bus.mem_din), 32'h3C);
    apply_stimulus(32'h0000_0000, 1'b0, 8'h00);
    tick();
    check_output("ram_rd_0x00000", 32'(bus.mem_din), 32'hC3);
    apply_idle();
    tick();
    check_output("mem_din_hold_on_write", 32'(bus.mem_din), 32'hC3);
    apply_stimulus(32'h0000_0020, 1'b1, 8'h5A);
    tick();
    apply_stimulus(32'h0000_0020, 1'b0, 8'h00);
    tick();
    check_output("ram_rd_after_wr", 32'(bus.mem_din), 32'h5A);

    // TX: nonzero byte queued, zero byte filtered
    tx_ready = 1'b1;
    apply_stimulus(32'h0003_0000, 1'b1, 8'h41);
    tick();
    check_output("tx_valid_0x41", 32'(tx_valid), 32'h1);
    check_output("tx_data_0x41", 32'(tx_data), 32'h41);
    apply_stimulus(32'h0003_0000, 1'b1, 8'h00);
    tick();
    check_output("tx_zero_dropped", 32'(tx_valid), 32'h0);
    apply_idle();
    tx_ready = 1'b0;
    tick();

    // TX burst of 18 into a 16-deep FIFO with the UART stalled
    for (int i = 1; i <= 18; i++) begin
      apply_stimulus(32'h0003_0000, 1'b1, 8'(8'h10 + i));
      tick();
      check_output($sformatf("buf_full_after_push%0d", i), 32'(bus.io_buffer_full), 32'(i >= 14));
    end
    check_output("tx_overflow_set", 32'(tx_overflow), 32'h1);
    apply_idle();
    tx_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      #1;
      check_output($sformatf("drain_byte%0d", j), 32'(tx_data), 32'(8'(8'h11 + j)));
      tick();
    end
    check_output("drain_empty", 32'(tx_valid), 32'h0);
    check_output("overflow_sticky", 32'(tx_overflow), 32'h1);
    tx_ready = 1'b0;

    // Coherent counter read across a wrap
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    apply_stimulus(32'h0003_0004, 1'b0, 8'h00);
    tick();
    check_output("cnt_byte0", 32'(bus.mem_din), 32'hFE);
    assembled[7:0] = bus.mem_din;
    apply_stimulus(32'h0003_0005, 1'b0, 8'h00);
    tick();
    assembled[15:8] = bus.mem_din;
    apply_stimulus(32'h0003_0006, 1'b0, 8'h00);
    tick();
    assembled[23:16] = bus.mem_din;
    apply_stimulus(32'h0003_0007, 1'b0, 8'h00);
    tick();
    assembled[31:24] = bus.mem_din;
    check_output("cnt_assembled", assembled, 32'hFFFF_FFFE);
    apply_stimulus(32'h0003_0004, 1'b0, 8'h00);
    tick();
    check_output("cnt_after_wrap", 32'(bus.mem_din), 32'h02);

    // UART RX read with and without a pending byte
    rx_valid = 1'b1;
    rx_data  = 8'h7E;
    apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
    check_output("rx_pop_valid", 32'(rx_pop), 32'h1);
    tick();
    check_output("rx_data_read", 32'(bus.mem_din), 32'h7E);
    rx_valid = 1'b0;
    rx_data  = 8'h99;
    apply_stimulus(32'h0003_0000, 1'b0, 8'h00);
    check_output("rx_pop_empty", 32'(rx_pop), 32'h0);
    tick();
    check_output("rx_read_empty", 32'(bus.mem_din), 32'h00);

    // Program stop queues a zero byte, then reset flushes the FIFO
    apply_stimulus(32'h0003_0004, 1'b1, 8'h00);
    check_output("prog_stop_pulse", 32'(program_stop), 32'h1);
    tick();
    apply_idle();
    check_output("prog_stop_low", 32'(program_stop), 32'h0);
    check_output("stop_zero_queued", 32'(tx_valid), 32'h1);
    check_output("stop_zero_data", 32'(tx_data), 32'h00);
    apply_stimulus(32'h0003_0000, 1'b1, 8'h55);
    tick();
    apply_stimulus(32'h0003_0000, 1'b1, 8'h66);
    tick();
    apply_idle();
    check_output("three_queued_not_full", 32'(bus.io_buffer_full), 32'h0);
    rst_in = 1'b1;
    apply_stimulus(32'h0000_0010, 1'b0, 8'h00);
    tick();
    check_output("midrst_tx_valid", 32'(tx_valid), 32'h0);
    check_output("midrst_mem_din", 32'(bus.mem_din), 32'h00);
    check_output("midrst_counter", dut.cycle_cnt, 32'h0);
    check_output("midrst_overflow", 32'(tx_overflow), 32'h0);
    rst_in = 1'b0;
    apply_idle();
    tick();
    check_output("post_rst_tx_valid", 32'(tx_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU byte-wide memory bus (mem_a / mem_dout / mem_wr / mem_din).
- Provides 128 KB byte-addressable RAM with one-cycle read latency.
- Decodes the I/O window mem_a[17:16]==2'b11:
  - 0x30000: UART RX/TX byte port.
  - 0x30004: 32-bit cycle counter read / program-stop write.
- Owns the TX buffer and generates io_buffer_full back to the CPU.

Parameters:
RAM_AW, 17, RAM byte-address width (2^17 bytes)
TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (default 16 entries)
FULL_MARGIN, 2, io_buffer_full asserts when free entries <= FULL_MARGIN

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
mem_a  in  32  address from CPU; only [17:0] decoded
mem_dout  in  8  write data from CPU
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data to CPU, valid the cycle after the address
io_buffer_full  out  1  TX FIFO near full
rx_data  in  8  UART receive byte
rx_valid  in  1  rx_data holds an unread byte
rx_pop  out  1  one-cycle pulse consuming rx_data
tx_data  out  8  TX FIFO head byte
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  UART accepts tx_data this cycle
program_stop  out  1  one-cycle pulse on write to 0x30004
tx_overflow  out  1  sticky: a TX push was dropped because the FIFO was full

Behaviour:
- Interface: one clock, clk_in; reset rst_in is synchronous and active-high.
- Reset values:
  - mem_din=0, rx_pop=0, program_stop=0, tx_overflow=0.
  - TX FIFO empty: tx_valid=0, tx_data=0, io_buffer_full=0.
  - Cycle counter=0, snapshot=0.
  - RAM contents are not reset.
- Decode: io_sel = (mem_a[17:16]==2'b11). Otherwise RAM index = mem_a[RAM_AW-1:0].
- A bus access is evaluated every cycle; there is no idle state.
- RAM write: mem_wr=1 and !io_sel, so ram[idx] <= mem_dout at the clock edge.
- RAM read: mem_wr=0 and !io_sel, so mem_din <= ram[idx] at the edge; the data is visible the next cycle.
- Read-during-write to the same address on consecutive cycles returns the newly written byte.
- I/O write 0x30000:
  - mem_dout != 0: push mem_dout into the TX FIFO.
  - mem_dout == 0: the write is ignored.
- I/O write 0x30004:
  - program_stop pulses high for 1 cycle.
  - 0x00 is pushed into the TX FIFO, bypassing the zero filter.
- I/O read 0x30000:
  - rx_valid=1: mem_din <= rx_data and rx_pop=1 in the same cycle as the address.
  - rx_valid=0: mem_din <= 0 and rx_pop=0.
- Cycle counter: 32 bits; increments every cycle after reset; wraps 0xFFFFFFFF -> 0.
- I/O read 0x30004: snapshot <= counter, and mem_din <= counter[7:0] taken the same cycle.
- I/O reads 0x30005/6/7: mem_din <= snapshot[15:8] / [23:16] / [31:24]. This gives the CPU a coherent 4-byte load.
- Other I/O addresses: reads return 0; writes are ignored.
- mem_din for non-read cycles (mem_wr=1): holds its previous value.
- TX FIFO:
  - Circular buffer with a count register of width TX_DEPTH_LOG2+1.
  - tx_data = head entry; tx_valid = (count != 0).
  - Pop when tx_valid && tx_ready.
  - Push is accepted if count < depth, or if a pop occurs the same cycle.
  - Push onto a full FIFO with no pop: the byte is dropped and tx_overflow is set, sticky until reset.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pointers wrap modulo depth.
- io_buffer_full = (depth - count) <= FULL_MARGIN. It is combinational from count and covers the CPU's in-flight stores.
- Reset mid-operation: the FIFO is flushed and pending bytes are lost. A read issued in the reset cycle returns 0.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> mem_din=0xA5 exactly one cycle after the read address; back-to-back reads of 0x1FFFF/0x00000 return the correct bytes with no gap.
- Write 0x41 then 0x00 to 0x30000, tx_ready=1 -> exactly one byte 0x41 appears on tx_data with tx_valid; the zero byte is never emitted.
- tx_ready=0; write 18 nonzero bytes to 0x30000, depth 16 -> io_buffer_full rises after the 14th push; bytes 17-18 are dropped; tx_overflow=1; releasing tx_ready drains exactly 16 bytes in order.
- Preload counter near 0xFFFFFFFE (run cycles or force), read 0x30004..0x30007 over consecutive cycles -> the bytes reassemble to the counter value at the 0x30004 read cycle even though the counter wrapped during the sequence.
- rx_valid=1, rx_data=0x7E; read 0x30000 -> rx_pop pulses 1 cycle and mem_din=0x7E next cycle; repeat with rx_valid=0 -> mem_din=0, rx_pop=0.
- Write 0x00 to 0x30004 -> program_stop high for exactly 1 cycle and 0x00 is queued on TX; assert rst_in with 3 bytes queued -> next cycle tx_valid=0, counter=0.
